// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the instruction/data memory arbiter.
// Holds FSM states, owner encoding and default parameter values.
package mem_arb_pkg;

    // Transaction phases: idle/arbitrate, command issue, response wait
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_e;

    // Which requester owns the transaction in flight
    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_e;

    localparam int STARVE_MAX_DEF = 4;
    localparam int TIMEOUT_DEF    = 255;

    localparam logic [3:0] BE_FULL = 4'hF;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port (fetch / load-store) arbiter onto a single memory bus.
// Data has priority; a starvation counter forces a fetch grant.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_rdata,
    output logic        inst_done,

    input  logic        data_req,
    input  logic        data_we,
    input  logic [3:0]  data_be,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_done,

    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,

    output logic        bus_err,
    output logic        stall
);

    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

    state_e        state_q,      state_d;
    owner_e        owner_q,      owner_d;
    logic [SW-1:0] starve_q,     starve_d;
    logic [TW-1:0] tmo_q,        tmo_d;

    logic          mem_req_q,    mem_req_d;
    logic          mem_we_q,     mem_we_d;
    logic [3:0]    mem_be_q,     mem_be_d;
    logic [31:0]   mem_addr_q,   mem_addr_d;
    logic [31:0]   mem_wdata_q,  mem_wdata_d;

    logic [31:0]   inst_rdata_q, inst_rdata_d;
    logic [31:0]   data_rdata_q, data_rdata_d;
    logic          inst_done_q,  inst_done_d;
    logic          data_done_q,  data_done_d;
    logic          bus_err_q,    bus_err_d;

    logic          grant_inst;
    logic          tmo_hit;

    // Next-state and registered-output logic for the whole arbiter
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        starve_d     = starve_q;
        tmo_d        = tmo_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_be_d     = mem_be_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        inst_done_d  = 1'b0;
        data_done_d  = 1'b0;
        bus_err_d    = 1'b0;
        grant_inst   = 1'b0;
        tmo_hit      = (tmo_q == TMO_LAST);

        unique case (state_q)
            IDLE: begin
                if (inst_req || data_req) begin
                    grant_inst = inst_req &&
                                 (!data_req || starve_q == STARVE_LIM);
                    if (grant_inst) begin
                        owner_d     = OWN_INST;
                        mem_we_d    = 1'b0;
                        mem_be_d    = BE_FULL;
                        mem_addr_d  = inst_addr;
                        mem_wdata_d = 32'h0;
                        starve_d    = '0;
                    end else begin
                        owner_d     = OWN_DATA;
                        mem_we_d    = data_we;
                        mem_be_d    = data_be;
                        mem_addr_d  = data_addr;
                        mem_wdata_d = data_wdata;
                        if (!inst_req)
                            starve_d = '0;
                        else if (starve_q != STARVE_LIM)
                            starve_d = starve_q + 1'b1;
                    end
                    mem_req_d = 1'b1;
                    tmo_d     = '0;
                    state_d   = REQ;
                end
            end

            REQ: begin
                if (mem_gnt) begin
                    mem_req_d = 1'b0;
                    tmo_d     = '0;
                    state_d   = WAIT;
                end else if (tmo_hit) begin
                    mem_req_d = 1'b0;
                    bus_err_d = 1'b1;
                    state_d   = IDLE;
                    if (owner_q == OWN_INST) begin
                        inst_done_d  = 1'b1;
                        inst_rdata_d = 32'h0;
                    end else begin
                        data_done_d  = 1'b1;
                        data_rdata_d = 32'h0;
                    end
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            WAIT: begin
                if (mem_rvalid) begin
                    state_d = IDLE;
                    if (owner_q == OWN_INST) begin
                        inst_done_d  = 1'b1;
                        inst_rdata_d = mem_rdata;
                    end else begin
                        data_done_d  = 1'b1;
                        data_rdata_d = mem_rdata;
                    end
                end else if (tmo_hit) begin
                    bus_err_d = 1'b1;
                    state_d   = IDLE;
                    if (owner_q == OWN_INST) begin
                        inst_done_d  = 1'b1;
                        inst_rdata_d = 32'h0;
                    end else begin
                        data_done_d  = 1'b1;
                        data_rdata_d = 32'h0;
                    end
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            owner_q      <= OWN_INST;
            starve_q     <= '0;
            tmo_q        <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_be_q     <= 4'h0;
            mem_addr_q   <= 32'h0;
            mem_wdata_q  <= 32'h0;
            inst_rdata_q <= 32'h0;
            data_rdata_q <= 32'h0;
            inst_done_q  <= 1'b0;
            data_done_q  <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            starve_q     <= starve_d;
            tmo_q        <= tmo_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_be_q     <= mem_be_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
            inst_done_q  <= inst_done_d;
            data_done_q  <= data_done_d;
            bus_err_q    <= bus_err_d;
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_be     = mem_be_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign inst_rdata = inst_rdata_q;
    assign data_rdata = data_rdata_q;
    assign inst_done  = inst_done_q;
    assign data_done  = data_done_q;
    assign bus_err    = bus_err_q;

    // A requester stalls until its own completion pulse is seen
    assign stall = (inst_req & ~inst_done_q) | (data_req & ~data_done_q);

endmodule
